// File: rtl/nic_counter_bank.sv
// Parametrised statistics counter bank: N channels with per-event increments,
// wrap/saturate overflow, sticky flags, snapshot bank and a one-cycle read port.
module nic_counter_bank #(
  parameter int N_COUNTERS = 8,
  parameter int CNT_WIDTH  = 64,
  parameter int INC_WIDTH  = 16,
  parameter int ID_WIDTH   = 8,
  parameter int SATURATE   = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_COUNTERS-1:0]           event_valid_in,
  input  logic [N_COUNTERS*INC_WIDTH-1:0] event_inc_in,
  input  logic                            clear_all_in,
  input  logic                            snapshot_in,
  input  logic                            rd_req_in,
  input  logic [ID_WIDTH-1:0]             rd_id_in,
  input  logic                            rd_snap_in,
  input  logic                            rd_clear_in,
  output logic                            rd_valid_out,
  output logic [CNT_WIDTH-1:0]            rd_value_out,
  output logic                            rd_err_out,
  output logic [N_COUNTERS-1:0]           overflow_out
);

  logic [N_COUNTERS-1:0]           ev_valid_q, ev_valid_d;
  logic [N_COUNTERS*INC_WIDTH-1:0] ev_inc_q, ev_inc_d;
  logic [CNT_WIDTH-1:0]            cnt_q  [N_COUNTERS];
  logic [CNT_WIDTH-1:0]            cnt_d  [N_COUNTERS];
  logic [CNT_WIDTH-1:0]            snap_q [N_COUNTERS];
  logic [CNT_WIDTH-1:0]            snap_d [N_COUNTERS];
  logic [N_COUNTERS-1:0]           ovf_q, ovf_d;
  logic                            rd_valid_q, rd_valid_d;
  logic                            rd_err_q, rd_err_d;
  logic [CNT_WIDTH-1:0]            rd_value_q, rd_value_d;

  logic [N_COUNTERS-1:0]           id_sel;
  logic                            in_range;
  logic                            live_clr;
  logic [CNT_WIDTH-1:0]            rd_mux;
  logic [CNT_WIDTH-1:0]            inc_ext [N_COUNTERS];
  logic [CNT_WIDTH:0]              sum     [N_COUNTERS];

  // Input stage: events are registered once before reaching the counters.
  always_comb begin
    ev_valid_d = event_valid_in;
    ev_inc_d   = event_inc_in;
  end

  // Read address decode and N:1 mux; an id with no matching channel is out of range.
  always_comb begin
    id_sel = '0;
    rd_mux = '0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      if (rd_id_in == ID_WIDTH'(i)) begin
        id_sel[i] = 1'b1;
        rd_mux    = rd_snap_in ? snap_q[i] : cnt_q[i];
      end else begin
        id_sel[i] = 1'b0;
      end
    end
    in_range = |id_sel;
    live_clr = rd_req_in & rd_clear_in & ~rd_snap_in & in_range;
  end

  // Counter, overflow and snapshot next-state; clear-on-read keeps the pending increment.
  always_comb begin
    for (int i = 0; i < N_COUNTERS; i++) begin
      inc_ext[i] = CNT_WIDTH'(ev_inc_q[i*INC_WIDTH +: INC_WIDTH]);
      sum[i]     = (CNT_WIDTH+1)'(cnt_q[i]) + (CNT_WIDTH+1)'(inc_ext[i]);
      cnt_d[i]   = cnt_q[i];
      ovf_d[i]   = ovf_q[i];
      if (clear_all_in) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (live_clr && id_sel[i]) begin
        cnt_d[i] = ev_valid_q[i] ? inc_ext[i] : '0;
        ovf_d[i] = 1'b0;
      end else if (ev_valid_q[i]) begin
        if (sum[i][CNT_WIDTH]) begin
          cnt_d[i] = (SATURATE != 0) ? '1 : sum[i][CNT_WIDTH-1:0];
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = sum[i][CNT_WIDTH-1:0];
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end

      if (clear_all_in) begin
        snap_d[i] = '0;
      end else if (snapshot_in) begin
        snap_d[i] = cnt_q[i];
      end else begin
        snap_d[i] = snap_q[i];
      end
    end
  end

  // Read response: value holds between requests, error only qualifies a valid beat.
  always_comb begin
    rd_valid_d = rd_req_in;
    rd_err_d   = rd_req_in & ~in_range;
    if (rd_req_in) begin
      rd_value_d = rd_mux;
    end else begin
      rd_value_d = rd_value_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_valid_q <= '0;
      ev_inc_q   <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_value_q <= '0;
      for (int i = 0; i < N_COUNTERS; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      ev_valid_q <= ev_valid_d;
      ev_inc_q   <= ev_inc_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_value_q <= rd_value_d;
      for (int i = 0; i < N_COUNTERS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign rd_valid_out = rd_valid_q;
  assign rd_err_out   = rd_err_q;
  assign rd_value_out = rd_value_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_nic_counter_bank.sv
// Directed bench for nic_counter_bank: a 64-bit wrap instance plus 8-bit wrap and
// saturate instances sharing the same stimulus.
module tb_nic_counter_bank;

  localparam int N   = 8;
  localparam int INC = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   event_valid_in;
  logic [N*INC-1:0] event_inc_in;
  logic           clear_all_in, snapshot_in;
  logic           rd_req_in, rd_snap_in, rd_clear_in;
  logic [7:0]     rd_id_in;

  logic           m_valid, w_valid, s_valid;
  logic [63:0]    m_value;
  logic [7:0]     w_value, s_value;
  logic           m_err, w_err, s_err;
  logic [N-1:0]   m_ovf, w_ovf, s_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nic_counter_bank #(.N_COUNTERS(N), .CNT_WIDTH(64), .INC_WIDTH(INC), .ID_WIDTH(8), .SATURATE(0)) dut_m (
    .clk(clk), .reset_n(reset_n), .event_valid_in(event_valid_in), .event_inc_in(event_inc_in),
    .clear_all_in(clear_all_in), .snapshot_in(snapshot_in), .rd_req_in(rd_req_in), .rd_id_in(rd_id_in),
    .rd_snap_in(rd_snap_in), .rd_clear_in(rd_clear_in), .rd_valid_out(m_valid), .rd_value_out(m_value),
    .rd_err_out(m_err), .overflow_out(m_ovf));

  nic_counter_bank #(.N_COUNTERS(N), .CNT_WIDTH(8), .INC_WIDTH(INC), .ID_WIDTH(8), .SATURATE(0)) dut_w (
    .clk(clk), .reset_n(reset_n), .event_valid_in(event_valid_in), .event_inc_in(event_inc_in),
    .clear_all_in(clear_all_in), .snapshot_in(snapshot_in), .rd_req_in(rd_req_in), .rd_id_in(rd_id_in),
    .rd_snap_in(rd_snap_in), .rd_clear_in(rd_clear_in), .rd_valid_out(w_valid), .rd_value_out(w_value),
    .rd_err_out(w_err), .overflow_out(w_ovf));

  nic_counter_bank #(.N_COUNTERS(N), .CNT_WIDTH(8), .INC_WIDTH(INC), .ID_WIDTH(8), .SATURATE(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .event_valid_in(event_valid_in), .event_inc_in(event_inc_in),
    .clear_all_in(clear_all_in), .snapshot_in(snapshot_in), .rd_req_in(rd_req_in), .rd_id_in(rd_id_in),
    .rd_snap_in(rd_snap_in), .rd_clear_in(rd_clear_in), .rd_valid_out(s_valid), .rd_value_out(s_value),
    .rd_err_out(s_err), .overflow_out(s_ovf));

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ev(input logic [N-1:0] mask, input logic [15:0] inc);
    event_valid_in = mask;
    for (int i = 0; i < N; i++) event_inc_in[i*INC +: INC] = inc;
    tick();
    event_valid_in = '0;
    event_inc_in   = '0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic snap, input logic clr);
    rd_req_in   = 1'b1;
    rd_id_in    = id;
    rd_snap_in  = snap;
    rd_clear_in = clr;
    tick();
    rd_req_in   = 1'b0;
    rd_snap_in  = 1'b0;
    rd_clear_in = 1'b0;
  endtask

  task automatic clear_all();
    clear_all_in = 1'b1;
    tick();
    clear_all_in = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    event_valid_in = '0; event_inc_in = '0;
    clear_all_in = 1'b0; snapshot_in = 1'b0;
    rd_req_in = 1'b0; rd_snap_in = 1'b0; rd_clear_in = 1'b0; rd_id_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_value("reset_valid", 64'(m_valid), 64'd0);
    check_value("reset_value", m_value, 64'd0);
    check_value("reset_err", 64'(m_err), 64'd0);
    check_value("reset_ovf", 64'(m_ovf), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Every channel reads zero after reset, one valid beat per request.
    for (int i = 0; i < N; i++) begin
      do_read(8'(i), 1'b0, 1'b0);
      check_value($sformatf("rst_rd%0d_valid", i), 64'(m_valid), 64'd1);
      check_value($sformatf("rst_rd%0d_value", i), m_value, 64'd0);
      check_value($sformatf("rst_rd%0d_err", i), 64'(m_err), 64'd0);
    end
    tick();
    check_value("valid_one_cycle", 64'(m_valid), 64'd0);

    // Ten back-to-back events of 64 on channel 3.
    for (int k = 0; k < 10; k++) send_ev(8'h08, 16'd64);
    tick();
    do_read(8'd3, 1'b0, 1'b0);
    check_value("ch3_640", m_value, 64'd640);
    do_read(8'd2, 1'b0, 1'b0);
    check_value("ch2_zero", m_value, 64'd0);

    // All channels at once with distinct increments i+1.
    event_valid_in = 8'hFF;
    for (int i = 0; i < N; i++) event_inc_in[i*INC +: INC] = 16'(i + 1);
    tick();
    event_valid_in = '0;
    event_inc_in   = '0;
    tick();
    for (int i = 0; i < N; i++) begin
      do_read(8'(i), 1'b0, 1'b0);
      check_value($sformatf("all_ch%0d", i), m_value, (i == 3) ? 64'd644 : 64'(i + 1));
    end

    // Overflow on ch0: 250 + 10 at 8 bits.
    clear_all();
    check_value("clear_ovf", 64'(m_ovf), 64'd0);
    send_ev(8'h01, 16'd250);
    send_ev(8'h01, 16'd10);
    tick();
    do_read(8'd0, 1'b0, 1'b0);
    check_value("wrap_value", 64'(w_value), 64'd4);
    check_value("wrap_ovf", 64'(w_ovf), 64'h01);
    check_value("sat_value", 64'(s_value), 64'd255);
    check_value("sat_ovf", 64'(s_ovf), 64'h01);
    check_value("wide_no_ovf", 64'(m_ovf), 64'd0);
    send_ev(8'h01, 16'd10);
    tick();
    do_read(8'd0, 1'b0, 1'b0);
    check_value("wrap_again", 64'(w_value), 64'd14);
    check_value("sat_hold", 64'(s_value), 64'd255);
    check_value("sat_ovf_sticky", 64'(s_ovf), 64'h01);
    check_value("wide_270", m_value, 64'd270);

    // Clear-on-read of ch1 racing a registered increment of 5.
    clear_all();
    send_ev(8'h02, 16'd200);
    send_ev(8'h02, 16'd156);
    tick();
    check_value("pre_cor_ovf_w", 64'(w_ovf), 64'h02);
    send_ev(8'h02, 16'd5);
    do_read(8'd1, 1'b0, 1'b1);
    check_value("cor_old_m", m_value, 64'd356);
    check_value("cor_old_w", 64'(w_value), 64'd100);
    check_value("cor_old_s", 64'(s_value), 64'd255);
    do_read(8'd1, 1'b0, 1'b0);
    check_value("cor_new_m", m_value, 64'd5);
    check_value("cor_new_w", 64'(w_value), 64'd5);
    check_value("cor_ovf_w", 64'(w_ovf), 64'd0);
    check_value("cor_ovf_s", 64'(s_ovf), 64'd0);

    // Snapshot 7/9, then three more events on each channel.
    clear_all();
    event_valid_in = 8'h03;
    event_inc_in[0 +: INC]   = 16'd7;
    event_inc_in[INC +: INC] = 16'd9;
    tick();
    event_valid_in = '0;
    event_inc_in   = '0;
    tick();
    snapshot_in = 1'b1;
    tick();
    snapshot_in = 1'b0;
    for (int k = 0; k < 3; k++) send_ev(8'h03, 16'd1);
    tick();
    do_read(8'd0, 1'b1, 1'b0);
    check_value("snap_ch0", m_value, 64'd7);
    do_read(8'd1, 1'b1, 1'b1);
    check_value("snap_ch1", m_value, 64'd9);
    do_read(8'd0, 1'b0, 1'b0);
    check_value("live_ch0", m_value, 64'd10);
    do_read(8'd1, 1'b0, 1'b0);
    check_value("live_ch1_no_clear", m_value, 64'd12);
    clear_all_in = 1'b1;
    snapshot_in  = 1'b1;
    tick();
    clear_all_in = 1'b0;
    snapshot_in  = 1'b0;
    do_read(8'd1, 1'b1, 1'b0);
    check_value("clr_snap_ch1", m_value, 64'd0);
    do_read(8'd1, 1'b0, 1'b0);
    check_value("clr_live_ch1", m_value, 64'd0);

    // Out-of-range id, then the error flag drops while the value holds.
    send_ev(8'h04, 16'd33);
    tick();
    do_read(8'd2, 1'b0, 1'b0);
    check_value("ch2_33", m_value, 64'd33);
    do_read(8'd200, 1'b0, 1'b1);
    check_value("oor_valid", 64'(m_valid), 64'd1);
    check_value("oor_err", 64'(m_err), 64'd1);
    check_value("oor_value", m_value, 64'd0);
    tick();
    check_value("idle_err", 64'(m_err), 64'd0);
    check_value("idle_hold", m_value, 64'd0);
    do_read(8'd2, 1'b0, 1'b0);
    check_value("oor_no_side_effect", m_value, 64'd33);

    // Reset while a read and an event are in flight.
    event_valid_in = 8'h04;
    event_inc_in[2*INC +: INC] = 16'd9;
    rd_req_in = 1'b1;
    rd_id_in  = 8'd2;
    tick();
    event_valid_in = '0;
    event_inc_in   = '0;
    rd_req_in = 1'b0;
    reset_n = 1'b0;
    #1;
    check_value("midrst_valid", 64'(m_valid), 64'd0);
    check_value("midrst_value", m_value, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_value("post_rst_valid", 64'(m_valid), 64'd0);
    check_value("post_rst_value", m_value, 64'd0);
    check_value("post_rst_ovf", 64'(m_ovf), 64'd0);
    tick();
    do_read(8'd2, 1'b0, 1'b0);
    check_value("pending_dropped", m_value, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nic_counter_bank.md
Name: nic_counter_bank

Overview:
- Parametrised statistics counter bank for the NIC datapath, replacing fixed four-counter instances with N generic channels.
- Each channel accumulates a per-event increment, so one block can count both packets and bytes.
- Features: wrap or saturate mode, sticky overflow flags, global clear, atomic snapshot of all channels, and a valid-qualified read port with optional clear-on-read.
- Single clock domain. Cross-domain instances are placed per domain and read through their own port.

Parameters:
- N_COUNTERS, 8, number of channels (1..256).
- CNT_WIDTH, 64, counter width in bits.
- INC_WIDTH, 16, per-event increment width; must be <= CNT_WIDTH.
- ID_WIDTH, 8, read-select width; must satisfy 2^ID_WIDTH >= N_COUNTERS.
- SATURATE, 0, overflow mode: 0 = wrap modulo 2^CNT_WIDTH, 1 = clamp at all-ones.

Ports:
- clk, in, 1, the single clock; all logic is on its rising edge.
- reset_n, in, 1, asynchronous active-low reset; assertion is immediate, deassertion is synchronised externally.
- event_valid_in, in, N_COUNTERS, per-channel event strobe.
- event_inc_in, in, N_COUNTERS*INC_WIDTH, per-channel increment; channel i occupies [i*INC_WIDTH +: INC_WIDTH].
- clear_all_in, in, 1, zero all counters, snapshots and overflow flags.
- snapshot_in, in, 1, copy all live counters into the snapshot bank.
- rd_req_in, in, 1, single-cycle read request.
- rd_id_in, in, ID_WIDTH, channel to read.
- rd_snap_in, in, 1, 1 = read the snapshot bank, 0 = read the live counter.
- rd_clear_in, in, 1, clear-on-read of the addressed live counter.
- rd_valid_out, out, 1, read data valid.
- rd_value_out, out, CNT_WIDTH, read data.
- rd_err_out, out, 1, rd_id_in was >= N_COUNTERS.
- overflow_out, out, N_COUNTERS, sticky per-channel overflow flags.

Behaviour:
- Reset (reset_n low): all counters, snapshots, input stage, overflow_out, rd_valid_out, rd_value_out and rd_err_out go to 0 immediately.

Event stage and latency:
- event_valid_in and event_inc_in are registered once (stage _d).
- Counter i updates on the edge after capture: an event sampled at edge t is visible in the counter after edge t+1.
- event_valid high with increment 0 leaves the counter unchanged.

Arithmetic and overflow:
- The next value is cnt + zero-extended inc, computed at CNT_WIDTH+1 bits.
- Carry-out with SATURATE=0: store the low CNT_WIDTH bits and set overflow_out[i].
- Carry-out with SATURATE=1: store all-ones and set overflow_out[i]. Further events hold the counter at all-ones.
- overflow_out[i] stays set until clear_all_in, or until a live read of channel i with rd_clear_in.

Update priority per channel, per edge (first match wins):
1. clear_all_in: counter = 0.
2. Live clear-on-read hitting channel i: counter = pending increment (0 if none). Events are never lost, and an overflow cannot occur in this case.
3. Pending event: apply the increment.

Snapshot:
- snapshot_in at edge t copies every counter's pre-update value at edge t into the snapshot bank, for all channels in the same cycle.
- clear_all_in together with snapshot_in: the snapshot bank is zeroed; clear wins.
- Snapshots are never altered by events or by clear-on-read.

Read port:
- rd_req_in sampled at edge t produces rd_valid_out=1 for exactly the cycle after edge t. Latency is 1.
- Back-to-back requests are accepted every cycle; there is no backpressure.
- rd_value_out is the pre-update live counter value at edge t, or the snapshot value when rd_snap_in=1.
  - A read and an event on the same channel at the same edge return the old value.
  - A read and a snapshot at the same edge with rd_snap_in=1 return the old snapshot.
- rd_clear_in is ignored when rd_snap_in=1 or when the id is out of range.
- Out-of-range id: rd_value_out=0 and rd_err_out=1, with no side effects.
- When rd_valid_out=0: rd_value_out holds its last value and rd_err_out=0.
- rd_value_out is registered from a combinational N:1 mux.

Reset mid-operation:
- Asserting reset_n low while a read is in flight drops the read; rd_valid_out is 0 on the cycle after deassertion.
- Pending registered events are discarded.

Test Plan:
- Reset, then read every id 0..7 → rd_valid_out pulses one cycle after each request with value 0, err 0, overflow_out=0.
- 10 events with inc=64 on ch3 → after drain, read ch3 = 640 and ch2 = 0. Simultaneous events on all 8 channels update all channels independently.
- CNT_WIDTH=8, SATURATE=0: ch0 preset to 250, inc=10 → value 4, overflow_out[0]=1. Same test with SATURATE=1 → value 255, flag set. A further event keeps 255.
- Clear-on-read of ch1 (value 100) in the same cycle ch1 receives a registered inc=5 → read returns 100, and a subsequent read returns 5 with overflow_out[1] cleared.
- Counters at 7/9, pulse snapshot_in, then add 3 events to each → snapshot reads 7/9 and live reads 10/12. clear_all_in with snapshot_in → both banks read 0.
- rd_id_in=200 with N_COUNTERS=8 → rd_err_out=1 and value 0. Assert reset_n low mid-read → no rd_valid_out after release and all outputs 0.
